unified_mem_port: RTL and testbench

//   Unified instruction/data memory with a req/ready wait-state handshake for the multicycle RISC-V core.

---
 rtl/unified_mem_port.sv | 125 ++++++++++++
 tb/tb_unified_mem_port.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/unified_mem_port.sv
module unified_mem_port #(
  parameter int ADDR_W   = 10,
  parameter int LATENCY  = 2,
  parameter     INIT_HEX = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAT4 = 4'(LATENCY);

  logic [31:0] mem [2**ADDR_W];

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q;
  logic                ready_q, busy_q, mis_q;
  logic                commit, do_write, do_read;
  logic                unused_addr;

  assign unused_addr = ^addr[31:ADDR_W+2];

  // In IDLE the access fields come straight from the inputs, so a LATENCY=0
  // request can commit at the same edge it is accepted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    err_d   = err_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          idx_d   = addr[ADDR_W+1:2];
          wdata_d = wdata;
          cnt_d   = LAT4;
          err_d   = (addr[1:0] != 2'b00);
          if (err_d || (LATENCY == 0)) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    commit   = (state_q != DONE) && (state_d == DONE);
    do_write = commit && we_d && !err_d;
    do_read  = commit && !we_d && !err_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      ready_q <= (state_d == DONE);
      busy_q  <= (state_d != IDLE);
      mis_q   <= (state_d == DONE) && err_d;
      if (do_read) begin
        rdata_q <= mem[idx_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_write) begin
      mem[idx_d] <= wdata_d;
    end
  end

  assign rdata      = rdata_q;
  assign ready      = ready_q;
  assign busy       = busy_q;
  assign misaligned = mis_q;

endmodule

// File: tb/tb_unified_mem_port.sv
// Scoreboard bench for unified_mem_port.
// Each access pushes its expected response, and a negedge monitor pops and
// compares it on every ready pulse.
module tb_unified_mem_port;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [31:0] addr, wdata, rdata;
    logic        ready, busy, misaligned;

    logic        req2, we2;
    logic [31:0] addr2, wdata2, rdata2;
    logic        ready2, busy2, mis2;

    int unsigned checks = 0;
    int unsigned passed = 0;

    typedef struct packed {
        logic [31:0] rd;
        logic        mis;
    } exp_t;
    exp_t        sb[$];
    logic [31:0] exp_rd;

    always #5 clk = ~clk;

    unified_mem_port #(.ADDR_W(10), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .busy(busy), .misaligned(misaligned)
    );

    unified_mem_port #(.ADDR_W(10), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
        .rdata(rdata2), .ready(ready2), .busy(busy2), .misaligned(mis2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    endtask

    // Compare every ready pulse of the main DUT with the oldest expectation.
    always @(negedge clk) begin
        if (ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_ready: got ready=1 expected no pending access");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rdata", rdata, e.rd);
                check("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
                check("busy_in_ready", {31'd0, busy}, 32'd1);
            end
        end
    end

    // Issue one access, optionally pulse a second req during WAIT, and wait for ready.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic erd_upd, input logic [31:0] erd,
                          input logic emis, input logic pulse);
        int cyc;
        if (erd_upd) exp_rd = erd;
        sb.push_back({exp_rd, emis});
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(negedge clk);
        req   = pulse;
        addr  = pulse ? 32'h0000_0040 : a;
        wdata = pulse ? 32'hCAFE_F00D : d;
        cyc = 1;
        while (ready !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            req = 1'b0;
            cyc++;
        end
        if (ready !== 1'b1) begin
            checks++;
            $display("FAIL timeout: got no ready after %0d cycles expected ready", cyc);
        end else if (!emis) begin
            check("latency", cyc, LAT + 1);
        end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        req2 = 1'b0; we2 = 1'b0; addr2 = '0; wdata2 = '0;
        exp_rd = '0;
        repeat (3) @(negedge clk);
        check("rst_rdata", rdata, 32'h0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_mis", {31'd0, misaligned}, 32'd0);
        rst = 1'b0;

        // Store, then load back the same word.
        access(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 1'b0);
        access(1'b0, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);

        // Misaligned load and store are rejected, and memory is untouched.
        access(1'b0, 32'h13, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        access(1'b1, 32'h12, 32'h0BAD_0BAD, 1'b0, 32'h0, 1'b1, 1'b0);
        access(1'b0, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);

        // Address wrap: 0x1000 aliases word 0.
        access(1'b1, 32'h1000, 32'h55, 1'b0, 32'h0, 1'b0, 1'b0);
        access(1'b0, 32'h0, 32'h0, 1'b1, 32'h55, 1'b0, 1'b0);

        // A second req pulsed during WAIT is ignored.
        access(1'b1, 32'h40, 32'h7777_7777, 1'b0, 32'h0, 1'b0, 1'b0);
        access(1'b0, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        access(1'b0, 32'h40, 32'h0, 1'b1, 32'h7777_7777, 1'b0, 1'b0);

        // Reset during WAIT drops the store and suppresses ready.
        access(1'b1, 32'h20, 32'h1111_1111, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h2222_2222;
        @(negedge clk);
        req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_ready", {31'd0, ready}, 32'd0);
        check("midrst_rdata", rdata, 32'h0);
        rst = 1'b0;
        exp_rd = '0;
        repeat (4) @(negedge clk);
        access(1'b0, 32'h20, 32'h0, 1'b1, 32'h1111_1111, 1'b0, 1'b0);

        // LATENCY=0 with req held high: ready on every second cycle, and busy only in DONE.
        @(negedge clk);
        req2 = 1'b1; we2 = 1'b0; addr2 = 32'h0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("lat0_ready", {31'd0, ready2}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("lat0_busy", {31'd0, busy2}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        req2 = 1'b0;

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
